// File: rtl/acc_pkg.sv
// acc_pkg: definitions shared by the accumulator, the ALU and the
// accumulator store arbiter.
//   ACC_DATA_W / ACC_ADDR_W : default data and address widths
//   state_t                 : store arbiter FSM state encoding
//   idx_width()             : width of a core index (at least one bit)
package acc_pkg;

  localparam int ACC_DATA_W = 16;
  localparam int ACC_ADDR_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

  // Returns the width of an index into n cores; one core still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/acc_store_arbiter_if.sv
// acc_store_arbiter_if: bundles the core request bus and the memory write
// port of the accumulator store arbiter.
//   req/addr_in/data_in : per-core store requests (core i at slice i)
//   ack                 : one-hot completion pulse back to the cores
//   mem_*               : data RAM write port (mem_ready from the RAM)
//   busy/grant_id/store_count : status
// Modports: slave = the arbiter, master = cores plus memory side.
interface acc_store_arbiter_if #(
  parameter int N_CORES = 4,
  parameter int DATA_W  = acc_pkg::ACC_DATA_W,
  parameter int ADDR_W  = acc_pkg::ACC_ADDR_W
);
  import acc_pkg::*;

  localparam int IDX_W = idx_width(N_CORES);

  logic [N_CORES-1:0]        req;
  logic [N_CORES*ADDR_W-1:0] addr_in;
  logic [N_CORES*DATA_W-1:0] data_in;
  logic [N_CORES-1:0]        ack;
  logic                      mem_wr_en;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic                      mem_ready;
  logic                      busy;
  logic [IDX_W-1:0]          grant_id;
  logic [15:0]               store_count;

  modport slave (
    input  req, addr_in, data_in, mem_ready,
    output ack, mem_wr_en, mem_addr, mem_wdata, busy, grant_id, store_count
  );

  modport master (
    output req, addr_in, data_in, mem_ready,
    input  ack, mem_wr_en, mem_addr, mem_wdata, busy, grant_id, store_count
  );

endinterface

// File: rtl/acc_store_arbiter_rr_select.sv
// rr_select: combinational round-robin pick.
//   req    : request vector, one bit per core
//   rr_ptr : index with the highest priority this round
//   g      : lowest requesting index >= rr_ptr, otherwise the lowest
//            requesting index overall (wrap-around)
//   valid  : at least one request is present
module rr_select
  import acc_pkg::*;
#(
  parameter int N_CORES = 4
) (
  input  logic [N_CORES-1:0]            req,
  input  logic [idx_width(N_CORES)-1:0] rr_ptr,
  output logic [idx_width(N_CORES)-1:0] g,
  output logic                          valid
);

  localparam int IDX_W = idx_width(N_CORES);

  logic [IDX_W-1:0] lo_idx;
  logic [IDX_W-1:0] hi_idx;
  logic             hi_found;

  // Scanning downwards makes the last hit the lowest index, both for the
  // whole vector and for the part at or above the pointer.
  always_comb begin
    lo_idx   = '0;
    hi_idx   = '0;
    hi_found = 1'b0;
    valid    = 1'b0;
    for (int i = N_CORES - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_idx = IDX_W'(i);
        valid  = 1'b1;
        if (i >= int'(rr_ptr)) begin
          hi_idx   = IDX_W'(i);
          hi_found = 1'b1;
        end
      end
    end
    g = hi_found ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/acc_store_arbiter.sv
// acc_store_arbiter: drains accumulator values from N_CORES cores into the
// shared data RAM, one write per round-robin grant, with a one-cycle ack.
//   clk : clock, rising edge
//   rst : asynchronous, active-low reset
//   bus : acc_store_arbiter_if.slave (core requests, RAM write port, status)
// All outputs are registered; a store takes at least three cycles
// (grant/write, ack, return to idle).
module acc_store_arbiter
  import acc_pkg::*;
#(
  parameter int N_CORES = 4,
  parameter int DATA_W  = ACC_DATA_W,
  parameter int ADDR_W  = ACC_ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  acc_store_arbiter_if.slave  bus
);

  localparam int IDX_W = idx_width(N_CORES);

  state_t             state_q, state_d;
  logic [N_CORES-1:0] ack_q, ack_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               busy_q, busy_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [15:0]        count_q, count_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic [IDX_W-1:0]   sel_g;
  logic               sel_valid;

  rr_select #(
    .N_CORES (N_CORES)
  ) u_rr_select (
    .req    (bus.req),
    .rr_ptr (rr_ptr_q),
    .g      (sel_g),
    .valid  (sel_valid)
  );

  // State and every output register; reset abandons any write in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      ack_q    <= '0;
      wr_en_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      busy_q   <= 1'b0;
      grant_q  <= '0;
      count_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      wr_en_q  <= wr_en_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
      grant_q  <= grant_d;
      count_q  <= count_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Next-state and next-output logic. Address and data are captured only
  // at grant time, so a core changing or dropping its request afterwards
  // does not disturb the write already under way.
  always_comb begin
    state_d  = state_q;
    ack_d    = ack_q;
    wr_en_d  = wr_en_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    busy_d   = busy_q;
    grant_d  = grant_q;
    count_d  = count_q;
    rr_ptr_d = rr_ptr_q;

    case (state_q)
      ST_IDLE: begin
        wr_en_d = 1'b0;
        if (sel_valid) begin
          for (int i = 0; i < N_CORES; i++) begin
            if (sel_g == IDX_W'(i)) begin
              addr_d  = bus.addr_in[i*ADDR_W +: ADDR_W];
              wdata_d = bus.data_in[i*DATA_W +: DATA_W];
            end
          end
          grant_d = sel_g;
          wr_en_d = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_WRITE;
        end
      end

      ST_WRITE: begin
        if (bus.mem_ready) begin
          wr_en_d        = 1'b0;
          ack_d          = '0;
          ack_d[grant_q] = 1'b1;
          count_d        = count_q + 16'd1;
          state_d        = ST_ACK;
        end
      end

      ST_ACK: begin
        ack_d   = '0;
        busy_d  = 1'b0;
        // The core after the one just served gets first priority next.
        if (grant_q == IDX_W'(N_CORES - 1)) begin
          rr_ptr_d = '0;
        end else begin
          rr_ptr_d = grant_q + IDX_W'(1);
        end
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.ack         = ack_q;
  assign bus.mem_wr_en   = wr_en_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.busy        = busy_q;
  assign bus.grant_id    = grant_q;
  assign bus.store_count = count_q;

endmodule

// File: tb/tb_acc_store_arbiter.sv
// tb_acc_store_arbiter: directed, self-checking bench for acc_store_arbiter
// (N_CORES=4, 16-bit data and address). A transaction-level model predicts
// every registered output; a compare process checks it each cycle and the
// directed sequence pins key values with hand-computed literals.
module tb_acc_store_arbiter;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  acc_store_arbiter_if #(.N_CORES(N)) bus ();

  acc_store_arbiter #(.N_CORES(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model: one open transaction at a time, described by who was granted,
  // what was captured and whether memory has taken it yet.
  logic [3:0]  m_ack;
  logic        m_wr_en;
  logic [15:0] m_addr;
  logic [15:0] m_wdata;
  logic        m_busy;
  logic [1:0]  m_grant;
  logic [15:0] m_count;
  int          m_ptr;
  bit          t_open;
  bit          t_written;
  int          pick;

  // Observation logs of the DUT.
  int   glog[$];
  int   gcyc[$];
  int   ack_pulses[N];
  int   cyc = 0;
  logic prev_wr = 1'b0;
  logic [3:0] drop_mask = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance n cycles; cores drop their request in the cycle after their ack.
  task automatic applyStimulus(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #2;
      bus.req   = bus.req & ~drop_mask;
      drop_mask = '0;
      #4;
      drop_mask = bus.ack;
    end
  endtask

  task automatic setCore(input int i, input logic [15:0] a, input logic [15:0] d);
    bus.addr_in[i*16 +: 16] = a;
    bus.data_in[i*16 +: 16] = d;
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ack = '0; m_wr_en = 1'b0; m_addr = '0; m_wdata = '0; m_busy = 1'b0;
      m_grant = '0; m_count = '0; m_ptr = 0; t_open = 1'b0; t_written = 1'b0;
    end else if (!t_open) begin
      m_wr_en = 1'b0;
      for (int k = 0; k < N; k++) begin
        pick = (m_ptr + k) % N;
        if (!t_open && bus.req[pick]) begin
          t_open    = 1'b1;
          t_written = 1'b0;
          m_grant   = 2'(pick);
          m_addr    = bus.addr_in[pick*16 +: 16];
          m_wdata   = bus.data_in[pick*16 +: 16];
          m_wr_en   = 1'b1;
          m_busy    = 1'b1;
        end
      end
    end else if (!t_written) begin
      if (bus.mem_ready) begin
        t_written = 1'b1;
        m_wr_en   = 1'b0;
        m_ack     = 4'(1 << m_grant);
        m_count   = m_count + 16'd1;
      end
    end else begin
      m_ack  = '0;
      m_busy = 1'b0;
      m_ptr  = (int'(m_grant) + 1) % N;
      t_open = 1'b0;
    end
  end

  // Per-cycle comparison against the model plus grant/ack logging.
  always @(negedge clk) begin
    if (rst && cmp_en) begin
      checkOutput("cyc_ack", 32'(bus.ack), 32'(m_ack));
      checkOutput("cyc_wr_en", 32'(bus.mem_wr_en), 32'(m_wr_en));
      checkOutput("cyc_addr", 32'(bus.mem_addr), 32'(m_addr));
      checkOutput("cyc_wdata", 32'(bus.mem_wdata), 32'(m_wdata));
      checkOutput("cyc_busy", 32'(bus.busy), 32'(m_busy));
      checkOutput("cyc_grant", 32'(bus.grant_id), 32'(m_grant));
      checkOutput("cyc_count", 32'(bus.store_count), 32'(m_count));
    end
    if (rst) begin
      if (bus.mem_wr_en && !prev_wr) begin
        glog.push_back(int'(bus.grant_id));
        gcyc.push_back(cyc);
      end
      for (int i = 0; i < N; i++) if (bus.ack[i]) ack_pulses[i]++;
    end
    prev_wr = bus.mem_wr_en;
  end

  task automatic checkZeroOutputs(input string tag);
    checkOutput({tag, "_ack"}, 32'(bus.ack), 32'h0);
    checkOutput({tag, "_wr_en"}, 32'(bus.mem_wr_en), 32'h0);
    checkOutput({tag, "_addr"}, 32'(bus.mem_addr), 32'h0);
    checkOutput({tag, "_wdata"}, 32'(bus.mem_wdata), 32'h0);
    checkOutput({tag, "_busy"}, 32'(bus.busy), 32'h0);
    checkOutput({tag, "_grant"}, 32'(bus.grant_id), 32'h0);
    checkOutput({tag, "_count"}, 32'(bus.store_count), 32'h0);
    checkOutput({tag, "_rr_ptr"}, 32'(dut.rr_ptr_q), 32'h0);
  endtask

  initial begin
    int exp_all[4];
    int exp_rr[5];
    int pulses_before;
    exp_all = '{0, 1, 2, 3};
    exp_rr  = '{2, 0, 2, 3, 0};
    for (int i = 0; i < N; i++) ack_pulses[i] = 0;
    bus.req = '0; bus.addr_in = '0; bus.data_in = '0; bus.mem_ready = 1'b1;

    $display("[TB] reset");
    applyStimulus(2);
    rst = 1'b1;
    #1;
    checkZeroOutputs("reset");
    cmp_en = 1'b1;

    $display("[TB] single store");
    setCore(0, 16'h0010, 16'h1234);
    bus.req = 4'b0001;
    applyStimulus(1);
    checkOutput("single_wr_en", 32'(bus.mem_wr_en), 32'h1);
    checkOutput("single_addr", 32'(bus.mem_addr), 32'h0010);
    checkOutput("single_wdata", 32'(bus.mem_wdata), 32'h1234);
    checkOutput("single_busy", 32'(bus.busy), 32'h1);
    applyStimulus(1);
    checkOutput("single_ack", 32'(bus.ack), 32'h1);
    checkOutput("single_wr_off", 32'(bus.mem_wr_en), 32'h0);
    checkOutput("single_count", 32'(bus.store_count), 32'h1);
    applyStimulus(2);
    checkOutput("single_ack_off", 32'(bus.ack), 32'h0);
    checkOutput("single_idle", 32'(bus.busy), 32'h0);

    $display("[TB] all cores requesting");
    rst = 1'b0;
    #1;
    rst = 1'b1;
    glog.delete();
    gcyc.delete();
    for (int i = 0; i < N; i++) setCore(i, 16'(16'h0100 + i), 16'(16'hA000 + i));
    bus.req = 4'b1111;
    applyStimulus(13);
    checkOutput("all_ngrants", 32'(glog.size()), 32'd4);
    for (int i = 0; i < 4 && i < glog.size(); i++)
      checkOutput("all_grant_order", 32'(glog[i]), 32'(exp_all[i]));
    for (int i = 1; i < gcyc.size(); i++)
      checkOutput("all_grant_spacing", 32'(gcyc[i] - gcyc[i-1]), 32'd3);
    checkOutput("all_count", 32'(bus.store_count), 32'd4);
    checkOutput("all_model_count", 32'(m_count), 32'd4);
    checkOutput("all_rr_ptr", 32'(dut.rr_ptr_q), 32'd0);
    checkOutput("all_model_ptr", 32'(m_ptr), 32'd0);
    checkOutput("all_req_cleared", 32'(bus.req), 32'h0);

    $display("[TB] round-robin fairness");
    glog.delete();
    bus.req = 4'b0100;
    applyStimulus(4);
    bus.req = 4'b0101;
    applyStimulus(8);
    bus.req = 4'b1001;
    applyStimulus(8);
    checkOutput("rr_ngrants", 32'(glog.size()), 32'd5);
    for (int i = 0; i < 5 && i < glog.size(); i++)
      checkOutput("rr_grant_order", 32'(glog[i]), 32'(exp_rr[i]));

    $display("[TB] memory stall");
    setCore(1, 16'h0020, 16'hBEEF);
    bus.mem_ready = 1'b0;
    bus.req = 4'b0010;
    pulses_before = ack_pulses[1];
    applyStimulus(1);
    checkOutput("stall_grant", 32'(bus.grant_id), 32'd1);
    for (int c = 0; c < 6; c++) begin
      checkOutput("stall_wr_en", 32'(bus.mem_wr_en), 32'h1);
      checkOutput("stall_addr", 32'(bus.mem_addr), 32'h0020);
      checkOutput("stall_wdata", 32'(bus.mem_wdata), 32'hBEEF);
      checkOutput("stall_no_ack", 32'(bus.ack), 32'h0);
      if (c < 5) applyStimulus(1);
    end
    bus.mem_ready = 1'b1;
    applyStimulus(1);
    checkOutput("stall_ack", 32'(bus.ack), 32'h2);
    applyStimulus(3);
    checkOutput("stall_one_pulse", 32'(ack_pulses[1] - pulses_before), 32'd1);

    $display("[TB] request withdrawn mid-write");
    bus.mem_ready = 1'b0;
    setCore(1, 16'h0030, 16'h5555);
    bus.req = 4'b0010;
    applyStimulus(1);
    checkOutput("wd_grant", 32'(bus.grant_id), 32'd1);
    checkOutput("wd_wdata_latched", 32'(bus.mem_wdata), 32'h5555);
    bus.req = 4'b0000;
    setCore(1, 16'h0030, 16'hFFFF);
    applyStimulus(1);
    checkOutput("wd_wdata_held", 32'(bus.mem_wdata), 32'h5555);
    bus.mem_ready = 1'b1;
    applyStimulus(1);
    checkOutput("wd_ack", 32'(bus.ack), 32'h2);
    checkOutput("wd_wdata_final", 32'(bus.mem_wdata), 32'h5555);
    applyStimulus(2);

    $display("[TB] reset during write");
    bus.mem_ready = 1'b0;
    setCore(0, 16'h0040, 16'h7777);
    bus.req = 4'b0001;
    applyStimulus(1);
    checkOutput("rst_pre_wr_en", 32'(bus.mem_wr_en), 32'h1);
    checkOutput("rst_pre_grant", 32'(bus.grant_id), 32'd0);
    rst = 1'b0;
    #1;
    checkZeroOutputs("rst_mid");
    bus.req = 4'b1000;
    setCore(3, 16'h0080, 16'h4242);
    bus.mem_ready = 1'b1;
    applyStimulus(1);
    checkOutput("rst_held_wr_en", 32'(bus.mem_wr_en), 32'h0);
    rst = 1'b1;
    applyStimulus(1);
    checkOutput("post_rst_wr_en", 32'(bus.mem_wr_en), 32'h1);
    checkOutput("post_rst_grant", 32'(bus.grant_id), 32'd3);
    checkOutput("post_rst_addr", 32'(bus.mem_addr), 32'h0080);
    checkOutput("post_rst_wdata", 32'(bus.mem_wdata), 32'h4242);
    applyStimulus(1);
    checkOutput("post_rst_ack", 32'(bus.ack), 32'h8);
    checkOutput("post_rst_count", 32'(bus.store_count), 32'd1);
    applyStimulus(2);
    checkOutput("core0_ack_total", 32'(ack_pulses[0]), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
